arm_dp_control_unit: RTL

- Multi-cycle control unit that sits directly upstream of the register file / ALU pair and drives every one of their control inputs.
- Fetches a 32-bit instruction over a simple MFA/MOC memory handshake and increments the PC through the register file's Pcin/LOADPC path.
- Decodes ARM data-processing instructions and evaluates the condition field against an internal flags register.
- Issues one execute cycle with RSLCT, OP, S, LOAD and ALU_OUT, then captures ALU flags when S=1.

---
 rtl/arm_dp_control_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/arm_dp_control_unit.sv
// arm_dp_control_unit
// Multi-cycle fetch/decode/execute sequencer for ARM data-processing
// instructions. It drives the control inputs of the register file and ALU.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, FETCH gives up
// after MOC_TIMEOUT cycles without MOC and parks in a sticky FAULT state.
module arm_dp_control_unit #(
    parameter int unsigned MOC_TIMEOUT = 15,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        MOC,
    input  logic [31:0] MEM_DATA,
    input  logic [31:0] PCout,
    input  logic [3:0]  FLAGS_OUT,
    output logic        MFA,
    output logic [31:0] Pcin,
    output logic        LOADPC,
    output logic        LOAD,
    output logic        IR_CU,
    output logic [19:0] RSLCT,
    output logic [4:0]  OP,
    output logic [3:0]  FLAGS,
    output logic        S,
    output logic        ALU_OUT,
    output logic        UNDEF,
    output logic        FAULT
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;
    logic        r_load;
    logic        r_s;
    logic        r_alu_out;
    logic [19:0] r_rslct;
    logic [4:0]  r_op;

    logic        w_fetch;
    logic        w_is_dp;
    logic        w_is_cmp;
    logic        w_cond_ok;
    logic [31:0] w_pc_next;

    // ARM condition-code evaluation; flags are packed {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;   // 1111 is treated as "never"
        endcase
    endfunction

    assign w_fetch   = (r_state == ST_FETCH);
    assign w_pc_next = PCout + PC_STEP;       // wraps naturally modulo 2^32
    assign w_is_dp   = (r_ir[27:26] == 2'b00);
    // Opcodes 8..11 (TST/TEQ/CMP/CMN) only set flags and never write Rd.
    assign w_is_cmp  = (r_ir[24:23] == 2'b10);
    assign w_cond_ok = cond_pass(r_ir[31:28], r_flags);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] r_wait;

    // Wait counter: zero outside FETCH, counts FETCH cycles that lack MOC.
    always_ff @(posedge Clk) begin
        if (RESET || !w_fetch) begin
            r_wait <= '0;
        end else if (!MOC) begin
            r_wait <= r_wait + 4'd1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (MOC_TIMEOUT != 0);
`endif

    // Main sequencer: state, instruction register, flags and execute controls.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_ir      <= '0;
            r_flags   <= '0;
            r_load    <= 1'b0;
            r_s       <= 1'b0;
            r_alu_out <= 1'b0;
            r_rslct   <= '0;
            r_op      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (MOC) begin
                        r_ir    <= MEM_DATA;
                        r_state <= ST_DECODE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_wait == 4'(MOC_TIMEOUT - 1)) begin
                        r_state <= ST_FAULT;
                    end
`endif
                end
                ST_DECODE: begin
                    if (!w_is_dp || !w_cond_ok) begin
                        r_state <= ST_FETCH;
                    end else begin
                        // Execute controls are registered here so they are
                        // stable for the whole EXEC cycle.
                        r_state   <= ST_EXEC;
                        r_alu_out <= 1'b1;
                        r_op      <= {1'b0, r_ir[24:21]};
                        r_s       <= r_ir[20] | w_is_cmp;
                        r_load    <= !w_is_cmp;
                        r_rslct   <= {r_ir[19:16], r_ir[15:12], r_ir[11:8],
                                      r_ir[3:0], r_ir[19:16]};
                    end
                end
                ST_EXEC: begin
                    if (r_s) begin
                        r_flags <= FLAGS_OUT;
                    end
                    r_load    <= 1'b0;
                    r_s       <= 1'b0;
                    r_alu_out <= 1'b0;
                    r_state   <= ST_FETCH;
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    logic w_unused_ir;
    assign w_unused_ir = ^{r_ir[25], r_ir[7:4]};   // immediate/shift ignored

    assign MFA     = w_fetch;
    assign LOADPC  = w_fetch && MOC;
    assign Pcin    = w_fetch ? w_pc_next : 32'd0;
    assign LOAD    = r_load;
    assign IR_CU   = 1'b1;
    assign RSLCT   = r_rslct;
    assign OP      = r_op;
    assign FLAGS   = r_flags;
    assign S       = r_s;
    assign ALU_OUT = r_alu_out;
    assign UNDEF   = (r_state == ST_DECODE) && !w_is_dp;
`ifdef MEM_TIMEOUT_EN
    assign FAULT   = (r_state == ST_FAULT);
`else
    assign FAULT   = 1'b0;
`endif

endmodule
